// File: rtl/bg_pkg.sv
// Shared types and constants for the background pixel scheduler.
package bg_pkg;

  typedef enum logic [1:0] {
    HIDDEN   = 2'd0,
    FADE_IN  = 2'd1,
    SHOWN    = 2'd2,
    FADE_OUT = 2'd3
  } fade_state_t;

  localparam logic [3:0] BG_LEVEL_MAX = 4'hF;
  localparam int         BG_W_DEF     = 320;
  localparam int         ROM_AW_DEF   = 17;

  // Brightness scaling: (ch * (lvl+1)) >> 4; the product never exceeds 240.
  function automatic logic [3:0] bg_scale(input logic [3:0] ch, input logic [3:0] lvl);
    logic [7:0] prod;
    prod = {4'b0, ch} * ({4'b0, lvl} + 8'd1);
    return prod[7:4];
  endfunction

endpackage

// File: rtl/bg_fade_ctrl.sv
// Frame-synchronous fade FSM: steps fade_level once every FADE_FRAMES frame_start pulses.
// A new-direction request restarts the frame count and discards any coincident step.
module bg_fade_ctrl
  import bg_pkg::*;
#(
  parameter int FADE_FRAMES = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_start_i,
  input  logic       fade_in_req_i,
  input  logic       fade_out_req_i,
  output logic [3:0] fade_level_o,
  output logic       fade_busy_o
);

  localparam int CW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FADE_FRAMES - 1);

  fade_state_t   state_q;
  logic [CW-1:0] frame_cnt_q;
  logic [3:0]    level_q;
  logic          busy_q;

  wire go_in = fade_in_req_i && !fade_out_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= HIDDEN;
      frame_cnt_q <= '0;
      level_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        HIDDEN: begin
          if (go_in) begin
            state_q     <= FADE_IN;
            frame_cnt_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        FADE_IN: begin
          if (fade_out_req_i) begin
            state_q     <= FADE_OUT;
            frame_cnt_q <= '0;
          end else if (frame_start_i) begin
            if (frame_cnt_q == CNT_LAST) begin
              frame_cnt_q <= '0;
              level_q     <= level_q + 4'd1;
              if (level_q == BG_LEVEL_MAX - 4'd1) begin
                state_q <= SHOWN;
                busy_q  <= 1'b0;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + CW'(1);
            end
          end
        end
        SHOWN: begin
          if (fade_out_req_i) begin
            state_q     <= FADE_OUT;
            frame_cnt_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (go_in) begin
            state_q     <= FADE_IN;
            frame_cnt_q <= '0;
          end else if (frame_start_i) begin
            if (frame_cnt_q == CNT_LAST) begin
              frame_cnt_q <= '0;
              level_q     <= level_q - 4'd1;
              if (level_q == 4'd1) begin
                state_q <= HIDDEN;
                busy_q  <= 1'b0;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= HIDDEN;
          level_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fade_level_o = level_q;
  assign fade_busy_o  = busy_q;

endmodule

// File: rtl/bg_pixel_scheduler.sv
// Background fetch pipeline: draw coords -> index-ROM address -> palette -> faded, registered RGB.
// Latency ROM_LATENCY+2 cycles from drawX/drawY/de to red/green/blue/de_out.
module bg_pixel_scheduler
  import bg_pkg::*;
#(
  parameter int ROM_LATENCY = 1,
  parameter int SCALE_SHIFT = 1,
  parameter int BG_W        = BG_W_DEF,
  parameter int ROM_AW      = ROM_AW_DEF,
  parameter int FADE_FRAMES = 4
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        drawX,
  input  logic [9:0]        drawY,
  input  logic              de,
  input  logic              frame_start,
  input  logic              fade_in_req,
  input  logic              fade_out_req,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pal_index,
  input  logic [11:0]       pal_rgb,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              de_out,
  output logic [3:0]        fade_level,
  output logic              fade_busy
);

  logic [ROM_AW-1:0]    rom_addr_q, rom_addr_d;
  logic [ROM_LATENCY:0] de_dly_q;
  logic [3:0]           red_q, green_q, blue_q;
  logic                 de_out_q;
  logic [3:0]           level_w;

  bg_fade_ctrl #(.FADE_FRAMES(FADE_FRAMES)) u_fade (
    .clk_i          (vga_clk),
    .rst_ni         (reset_n),
    .frame_start_i  (frame_start),
    .fade_in_req_i  (fade_in_req),
    .fade_out_req_i (fade_out_req),
    .fade_level_o   (level_w),
    .fade_busy_o    (fade_busy)
  );

  assign rom_addr_d = ROM_AW'(32'(drawY >> SCALE_SHIFT) * 32'(BG_W) + 32'(drawX >> SCALE_SHIFT));

  // de_dly_q[ROM_LATENCY] lines up with the palette colour of the same pixel.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      de_dly_q   <= '0;
      de_out_q   <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      de_dly_q   <= {de_dly_q[ROM_LATENCY-1:0], de};
      de_out_q   <= de_dly_q[ROM_LATENCY];
      if (de_dly_q[ROM_LATENCY]) begin
        red_q   <= bg_scale(pal_rgb[11:8], level_w);
        green_q <= bg_scale(pal_rgb[7:4],  level_w);
        blue_q  <= bg_scale(pal_rgb[3:0],  level_w);
      end else begin
        red_q   <= '0;
        green_q <= '0;
        blue_q  <= '0;
      end
    end
  end

  assign rom_addr   = rom_addr_q;
  assign pal_index  = rom_q;
  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;
  assign de_out     = de_out_q;
  assign fade_level = level_w;

endmodule
